// File: rtl/cache_pkg.sv
// Shared types and widths for the 4-way set-associative cache controller.
// Contents: geometry localparams, FSM state enum, latched-request payload,
// and the line-address helper used to form main-memory addresses.
package cache_pkg;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned CHANNELS       = 4;
  localparam int unsigned CH_NUM_WIDTH   = 2;
  localparam int unsigned AINDEX_WIDTH   = 8;
  localparam int unsigned OFFSET_WIDTH   = 3;
  localparam int unsigned CASH_STR_WIDTH = 64;
  localparam int unsigned TAG_WIDTH      = ADDR_WIDTH - AINDEX_WIDTH - OFFSET_WIDTH;
  localparam int unsigned BANKS          = 1 << AINDEX_WIDTH;
  localparam int unsigned STAT_WIDTH     = 32;

  localparam int unsigned INDEX_LSB = OFFSET_WIDTH;
  localparam int unsigned TAG_LSB   = OFFSET_WIDTH + AINDEX_WIDTH;

  typedef logic [ADDR_WIDTH-1:0]     addr_t;
  typedef logic [TAG_WIDTH-1:0]      tag_t;
  typedef logic [AINDEX_WIDTH-1:0]   index_t;
  typedef logic [CH_NUM_WIDTH-1:0]   way_t;
  typedef logic [CASH_STR_WIDTH-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  // CPU request as held for the duration of one transaction.
  typedef struct packed {
    logic   we;
    tag_t   tag;
    index_t index;
    line_t  wdata;
  } cpu_req_t;

  // Line-aligned byte address built from tag and set index.
  function automatic addr_t line_addr(input tag_t tag, input index_t index);
    return {tag, index, {OFFSET_WIDTH{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Tag/valid/dirty storage per [set][way] with parallel tag compare and
// victim selection (lowest invalid way, else per-set round-robin pointer).
// Ports:
//   clk, reset                 clock, async active-high reset (clears valid/dirty/pointers)
//   index, tag                 set and tag under lookup / update
//   hit_c, hit_way_c           combinational hit result
//   victim_way_c               way to replace on a miss
//   victim_dirty_c             victim holds a valid dirty line
//   victim_tag_c               tag currently stored in the victim way
//   fill_en/fill_way/fill_dirty  install tag in a way, advance the set's pointer
//   mark_dirty_en/mark_dirty_way set dirty on a write hit
module cache_tag_array
  import cache_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  index_t index,
  input  tag_t   tag,
  output logic   hit_c,
  output way_t   hit_way_c,
  output way_t   victim_way_c,
  output logic   victim_dirty_c,
  output tag_t   victim_tag_c,
  input  logic   fill_en,
  input  way_t   fill_way,
  input  logic   fill_dirty,
  input  logic   mark_dirty_en,
  input  way_t   mark_dirty_way
);

  tag_t                tag_q    [BANKS][CHANNELS];
  logic [CHANNELS-1:0] valid_q  [BANKS];
  logic [CHANNELS-1:0] dirty_q  [BANKS];
  way_t                rr_ptr_q [BANKS];

  logic found;
  way_t found_way;
  logic have_invalid;
  way_t invalid_way;

  // Tags need no reset: they are only meaningful where valid is set.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[index][fill_way] <= tag;
    end
  end

  // Valid/dirty bits and replacement pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < BANKS; s++) begin
        valid_q[s]  <= '0;
        dirty_q[s]  <= '0;
        rr_ptr_q[s] <= '0;
      end
    end else begin
      if (fill_en) begin
        valid_q[index][fill_way] <= 1'b1;
        dirty_q[index][fill_way] <= fill_dirty;
        rr_ptr_q[index]          <= rr_ptr_q[index] + way_t'(1);
      end else if (mark_dirty_en) begin
        dirty_q[index][mark_dirty_way] <= 1'b1;
      end
    end
  end

  // Scan high-to-low so the lowest-numbered match / invalid way wins.
  always_comb begin
    found        = 1'b0;
    found_way    = '0;
    have_invalid = 1'b0;
    invalid_way  = '0;
    for (int w = CHANNELS - 1; w >= 0; w--) begin
      if (valid_q[index][way_t'(w)] && (tag_q[index][way_t'(w)] == tag)) begin
        found     = 1'b1;
        found_way = way_t'(w);
      end
      if (!valid_q[index][way_t'(w)]) begin
        have_invalid = 1'b1;
        invalid_way  = way_t'(w);
      end
    end
  end

  assign hit_c          = found;
  assign hit_way_c      = found_way;
  assign victim_way_c   = have_invalid ? invalid_way : rr_ptr_q[index];
  assign victim_dirty_c = valid_q[index][victim_way_c] && dirty_q[index][victim_way_c];
  assign victim_tag_c   = tag_q[index][victim_way_c];

endmodule

// File: rtl/cache_controller.sv
// Sequencer for a 4-way set-associative line cache: hit/miss lookup,
// victim write-back and line fill against main memory, single request in flight.
// Sole driver of the external data store's index/channel/write strobe.
// Ports:
//   clk, reset                        clock, async active-high reset
//   cpu_req_*                         CPU line request (valid/ready handshake)
//   cpu_resp_*                        one-cycle response pulse with read line and hit flag
//   dm_index/dm_channel/dm_we/dm_wdata  data store addressing and write
//   dm_rdata                          data store combinational read data
//   mem_req/mem_we/mem_addr/mem_wdata main-memory request, held until mem_ack
//   mem_ack/mem_rdata                 main-memory completion and fill data
// Optional (CACHE_STATS_EN): stat_hits, stat_misses, stat_writebacks saturating counters.
module cache_controller
  import cache_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req_valid,
  output logic                      cpu_req_ready,
  input  logic                      cpu_req_we,
  input  logic [ADDR_WIDTH-1:0]     cpu_req_addr,
  input  logic [CASH_STR_WIDTH-1:0] cpu_req_wdata,
  output logic                      cpu_resp_valid,
  output logic [CASH_STR_WIDTH-1:0] cpu_resp_rdata,
  output logic                      cpu_resp_hit,
  output logic [AINDEX_WIDTH-1:0]   dm_index,
  output logic [CH_NUM_WIDTH-1:0]   dm_channel,
  output logic                      dm_we,
  output logic [CASH_STR_WIDTH-1:0] dm_wdata,
  input  logic [CASH_STR_WIDTH-1:0] dm_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [CASH_STR_WIDTH-1:0] mem_wdata,
  input  logic                      mem_ack,
  input  logic [CASH_STR_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]     stat_hits,
  output logic [STAT_WIDTH-1:0]     stat_misses,
  output logic [STAT_WIDTH-1:0]     stat_writebacks
`endif
);

  state_t   state_q;
  state_t   state_d;
  cpu_req_t req_q;
  way_t     victim_way_q;
  tag_t     victim_tag_q;
  line_t    resp_rdata_q;
  logic     resp_hit_q;

  logic     hit_c;
  way_t     hit_way_c;
  way_t     victim_way_c;
  logic     victim_dirty_c;
  tag_t     victim_tag_c;
  logic     fill_en;
  logic     mark_dirty_en;

  // Whole-line access: byte offset is deliberately ignored.
  logic unused_addr_offset;
  assign unused_addr_offset = ^cpu_req_addr[OFFSET_WIDTH-1:0];

  cache_tag_array u_tags (
    .clk            (clk),
    .reset          (reset),
    .index          (req_q.index),
    .tag            (req_q.tag),
    .hit_c          (hit_c),
    .hit_way_c      (hit_way_c),
    .victim_way_c   (victim_way_c),
    .victim_dirty_c (victim_dirty_c),
    .victim_tag_c   (victim_tag_c),
    .fill_en        (fill_en),
    .fill_way       (victim_way_q),
    .fill_dirty     (req_q.we),
    .mark_dirty_en  (mark_dirty_en),
    .mark_dirty_way (hit_way_c)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (cpu_req_valid) state_d = LOOKUP;
      LOOKUP: begin
        if (hit_c)               state_d = RESPOND;
        else if (victim_dirty_c) state_d = WRITEBACK;
        else                     state_d = FILL;
      end
      WRITEBACK: if (mem_ack) state_d = FILL;
      FILL:      if (mem_ack) state_d = RESPOND;
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode: data store, memory port, CPU response, tag-array updates.
  always_comb begin
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    cpu_resp_hit   = 1'b0;
    dm_index       = req_q.index;
    dm_channel     = '0;
    dm_we          = 1'b0;
    dm_wdata       = '0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    fill_en        = 1'b0;
    mark_dirty_en  = 1'b0;
    unique case (state_q)
      IDLE: cpu_req_ready = 1'b1;
      LOOKUP: begin
        dm_channel    = hit_way_c;
        dm_wdata      = req_q.wdata;
        dm_we         = hit_c && req_q.we;
        mark_dirty_en = hit_c && req_q.we;
      end
      WRITEBACK: begin
        dm_channel = victim_way_q;
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = line_addr(victim_tag_q, req_q.index);
        mem_wdata  = dm_rdata;
      end
      FILL: begin
        dm_channel = victim_way_q;
        mem_req    = 1'b1;
        mem_addr   = line_addr(req_q.tag, req_q.index);
        // Write-allocate: the fetched line is replaced wholesale by CPU data.
        dm_wdata   = req_q.we ? req_q.wdata : mem_rdata;
        dm_we      = mem_ack;
        fill_en    = mem_ack;
      end
      RESPOND: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_rdata = resp_rdata_q;
        cpu_resp_hit   = resp_hit_q;
      end
      default: ;
    endcase
  end

  // Request latch, victim capture and response data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q        <= '0;
      victim_way_q <= '0;
      victim_tag_q <= '0;
      resp_rdata_q <= '0;
      resp_hit_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && cpu_req_valid) begin
        req_q.we    <= cpu_req_we;
        req_q.tag   <= cpu_req_addr[TAG_LSB +: TAG_WIDTH];
        req_q.index <= cpu_req_addr[INDEX_LSB +: AINDEX_WIDTH];
        req_q.wdata <= cpu_req_wdata;
      end
      if (state_q == LOOKUP) begin
        resp_hit_q   <= hit_c;
        resp_rdata_q <= (hit_c && !req_q.we) ? dm_rdata : '0;
        victim_way_q <= victim_way_c;
        victim_tag_q <= victim_tag_c;
      end
      if (state_q == FILL && mem_ack) begin
        resp_rdata_q <= req_q.we ? '0 : mem_rdata;
      end
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else begin
      if (state_q == LOOKUP) begin
        if (hit_c) begin
          if (stat_hits != '1) stat_hits <= stat_hits + STAT_WIDTH'(1);
        end else begin
          if (stat_misses != '1) stat_misses <= stat_misses + STAT_WIDTH'(1);
        end
      end
      if (state_q == WRITEBACK && mem_ack && stat_writebacks != '1) begin
        stat_writebacks <= stat_writebacks + STAT_WIDTH'(1);
      end
    end
  end
`endif

endmodule
